cross_bar_arbiter: RTL and testbench
====================================

// Module: cross_bar_arbiter
//---------------------------------------------------------------------------------------------------------------
// PURPOSE
//   Per-slave round-robin arbiter for the cross bar. One instance per slave port.
//   Picks one of MASTER_N requesting masters, holds a one-hot grant until the slave acks
//   the single-beat transaction, then rotates priority.
//   The top level transposes the mgrant vectors of all instances into the per-master sgrant
//   vectors that select the ack/rdata return path.
// PARAMETERS
//   MASTER_N       4    number of masters (localparam from cross_bar_pkg)
//   TIMEOUT_CYCLES 256  grant watchdog limit in cycles; used only with CROSS_BAR_ARB_TIMEOUT_EN
// PORTS
//   clk         in   1         system clock, rising edge
//   rst         in   1         synchronous, active-high reset
//   master_req  in   MASTER_N  bit m: master m requests this slave (address already decoded)
//   slave_ack   in   1         slave completes the current transaction
//   mgrant      out  MASTER_N  one-hot grant (mgrant_t); all-zero when idle
//   slave_req   out  1         request forwarded to slave = |(mgrant & master_req)
//   busy        out  1         1 while in GRANT state
//   timeout     out  1         1-cycle pulse when watchdog forces a release; tied 0 if macro undefined
// BEHAVIOUR
//   - Reset (sync, active-high):
//     - mgrant=0, busy=0, timeout=0, state=IDLE.
//     - RR pointer=0, i.e. master 0 has highest priority.
//     - Reset mid-grant drops the grant on the next edge; no ack is forwarded.
//   - Outputs mgrant and busy are registered; slave_req is combinational from mgrant and master_req.
//   - State IDLE:
//     - If |master_req: the winner is the first set bit at or after ptr (wrapping modulo MASTER_N).
//     - mgrant<=onehot(winner), ->GRANT. Request-to-grant latency is 1 cycle.
//   - State GRANT (owner = index of mgrant):
//     - mgrant is held stable; requests from other masters are ignored.
//     - On slave_ack & slave_req:
//       - ptr<=owner+1 (wraps MASTER_N-1 -> 0).
//       - Re-arbitrate the same cycle over master_req with the owner bit masked off.
//       - Winner found: mgrant<=onehot(winner), stay in GRANT (back-to-back, zero idle cycles).
//       - Otherwise: mgrant<=0, ->IDLE.
//     - The owner may re-win only after a full cycle in IDLE or a grant to another master.
//     - Owner drops master_req without ack (abort): mgrant<=0, ->IDLE, ptr<=owner+1.
//   - slave_ack while IDLE, or while the owner's req is low, is ignored.
//   - Invariants:
//     - $onehot0(mgrant) always.
//     - A master with req held continuously is granted within MASTER_N grants.
// CONFIGURATION
//   CROSS_BAR_ARB_TIMEOUT_EN defined:
//     - Counter cnt counts cycles in GRANT; it is cleared on every new grant.
//     - At cnt==TIMEOUT_CYCLES-1 with no ack that cycle:
//       - mgrant<=0, ->IDLE, ptr<=owner+1.
//       - timeout pulses high for exactly 1 cycle, on the cycle after the release edge.
//     - Ack in the same cycle as expiry wins; no timeout pulse.
//   CROSS_BAR_ARB_TIMEOUT_EN undefined:
//     - No counter is built; timeout=0 constantly.
//     - A grant is held until ack or abort.
// STRUCTURE
//   cross_bar_pkg: add MASTER_N, mgrant_t (logic [MASTER_N-1:0]), arbiter state enum,
//     TIMEOUT_CYCLES constant.
//   Sub-module cross_bar_rr_picker (combinational):
//     - Inputs: req, mask, ptr.
//     - Outputs: one-hot winner, valid.
//     - Instantiated once and shared by the IDLE path and the GRANT re-arbitration path.
// TESTING (MASTER_N=4)
//   1. Single requester: req=4'b0100 at cyc0
//      -> mgrant=4'b0100 at cyc1; ack at cyc3 -> mgrant=0, busy=0 at cyc4.
//   2. Fairness: req=4'b1111 held, ack every cycle in GRANT
//      -> grant order 0,1,2,3,0; no idle cycle between grants.
//   3. No starvation of owner: req=4'b0011, ack of master 0
//      -> master 1 granted next, even though master 0 req is still high in the ack cycle.
//   4. Abort and stray ack:
//      - Owner 2 drops req without ack -> IDLE next cycle, ptr=3.
//      - Ack while IDLE -> no state change.
//   5. Reset mid-grant: rst=1 while mgrant=4'b1000
//      -> mgrant=0 next cycle; then req=4'b1001 -> master 0 wins.
//   6. Timeout (macro defined, TIMEOUT_CYCLES=8): grant with no ack
//      -> release after 8 cycles in GRANT, timeout pulse=1 for 1 cycle;
//      -> ack in cycle 8 -> no pulse.

Source files
------------

// File: rtl/cross_bar_pkg.sv
// Shared cross bar types and constants: master count, grant vector, arbiter
// state encoding and index helpers used by the per-slave arbiters.
package cross_bar_pkg;

   localparam int unsigned MASTER_N           = 4;
   localparam int unsigned PTR_W              = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;
   localparam int unsigned ARB_TIMEOUT_CYCLES = 256;

   typedef logic [MASTER_N-1:0] mgrant_t;
   typedef logic [PTR_W-1:0]    ptr_t;

   typedef enum logic {
      ARB_IDLE,
      ARB_GRANT
   } arb_state_t;

   // Index of the set bit of a one-hot vector (0 when empty).
   function automatic ptr_t onehot_to_idx(input mgrant_t v);
      ptr_t idx;
      idx = '0;
      for (int unsigned i = 0; i < MASTER_N; i++) begin
         if (v[i]) idx = PTR_W'(i);
      end
      return idx;
   endfunction

   // Round-robin successor, wrapping MASTER_N-1 back to 0.
   function automatic ptr_t next_ptr(input ptr_t p);
      if (32'(p) == MASTER_N - 1) return '0;
      else                        return p + 1'b1;
   endfunction

endpackage

// File: rtl/cross_bar_rr_picker.sv
// Combinational round-robin picker: selects the first requesting, unmasked
// master at or after ptr, wrapping modulo MASTER_N.
module cross_bar_rr_picker
   import cross_bar_pkg::*;
(
   input  mgrant_t req,
   input  mgrant_t mask,
   input  ptr_t    ptr,
   output mgrant_t winner,
   output logic    valid
);

   mgrant_t eligible;
   ptr_t    idx;

   assign eligible = req & ~mask;

   // Scan candidates in priority order starting at ptr; first hit wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int unsigned i = 0; i < MASTER_N; i++) begin
         idx = PTR_W'((32'(ptr) + i) % MASTER_N);
         if (!valid && eligible[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cross_bar_arbiter.sv
// Per-slave round-robin arbiter. Holds a one-hot grant until the slave acks,
// then rotates priority and re-arbitrates in the same cycle.
// Optional grant watchdog enabled by defining CROSS_BAR_ARB_TIMEOUT_EN.
module cross_bar_arbiter
   import cross_bar_pkg::*;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
)
`endif
(
   input  logic    clk,
   input  logic    rst,
   input  mgrant_t master_req,
   input  logic    slave_ack,
   output mgrant_t mgrant,
   output logic    slave_req,
   output logic    busy,
   output logic    timeout
);

   arb_state_t state;
   ptr_t       ptr;
   ptr_t       owner;
   ptr_t       pick_ptr;
   mgrant_t    pick_mask;
   mgrant_t    pick_winner;
   logic       pick_valid;
   logic       ack_hit;
   logic       expire;

   assign owner     = onehot_to_idx(mgrant);
   assign slave_req = |(mgrant & master_req);
   assign ack_hit   = slave_ack & slave_req;

   // In GRANT the picker searches from the rotated pointer with the owner
   // masked, so the owner cannot re-win on its own ack.
   assign pick_mask = (state == ARB_GRANT) ? mgrant : '0;
   assign pick_ptr  = (state == ARB_GRANT) ? next_ptr(owner) : ptr;

   cross_bar_rr_picker u_picker (
      .req    (master_req),
      .mask   (pick_mask),
      .ptr    (pick_ptr),
      .winner (pick_winner),
      .valid  (pick_valid)
   );

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] cnt;
   logic             timeout_q;

   assign expire  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout = timeout_q;

   // Watchdog: counts cycles of the current grant, pulses on forced release.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= (state == ARB_GRANT) && slave_req && !slave_ack && expire;
         if ((state == ARB_GRANT) && slave_req && !slave_ack && !expire)
            cnt <= cnt + 1'b1;
         else
            cnt <= '0;
      end
   end
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

   // Arbitration FSM with registered grant, busy and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ARB_IDLE;
         mgrant <= '0;
         busy   <= 1'b0;
         ptr    <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_valid) begin
                  mgrant <= pick_winner;
                  busy   <= 1'b1;
                  state  <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               if (ack_hit) begin
                  ptr <= next_ptr(owner);
                  if (pick_valid) begin
                     mgrant <= pick_winner;
                  end else begin
                     mgrant <= '0;
                     busy   <= 1'b0;
                     state  <= ARB_IDLE;
                  end
               end else if (!slave_req || expire) begin
                  ptr    <= next_ptr(owner);
                  mgrant <= '0;
                  busy   <= 1'b0;
                  state  <= ARB_IDLE;
               end
            end
            default: begin
               state  <= ARB_IDLE;
               mgrant <= '0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cross_bar_arbiter.sv
// Self-checking bench for cross_bar_arbiter: integer-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_cross_bar_arbiter;
   import cross_bar_pkg::*;

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int TMO_CYC = 8;

   logic    clk = 1'b0;
   logic    rst = 1'b1;
   mgrant_t master_req = '0;
   logic    slave_ack = 1'b0;
   mgrant_t mgrant;
   logic    slave_req;
   logic    busy;
   logic    timeout;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // model state
   int m_owner = -1;
   int m_ptr   = 0;
   int m_cnt   = 0;
   bit m_tmo   = 1'b0;

   always #5 clk = ~clk;

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
   cross_bar_arbiter #(.TIMEOUT_CYCLES(TMO_CYC)) dut (
      .clk(clk), .rst(rst), .master_req(master_req), .slave_ack(slave_ack),
      .mgrant(mgrant), .slave_req(slave_req), .busy(busy), .timeout(timeout));
`else
   cross_bar_arbiter dut (
      .clk(clk), .rst(rst), .master_req(master_req), .slave_ack(slave_ack),
      .mgrant(mgrant), .slave_req(slave_req), .busy(busy), .timeout(timeout));
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // First requesting master scanning from start, skipping 'skip'; -1 if none.
   function automatic int rr_pick(input mgrant_t req, input int start, input int skip);
      for (int k = 0; k < int'(MASTER_N); k++) begin
         int m;
         m = (start + k) % int'(MASTER_N);
         if (m != skip && req[m]) return m;
      end
      return -1;
   endfunction

   function automatic mgrant_t exp_grant();
      mgrant_t g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   // Reference model: advances one transaction-level step per clock.
   always @(posedge clk) begin
      m_tmo = 1'b0;
      if (rst) begin
         m_owner = -1;
         m_ptr   = 0;
         m_cnt   = 0;
      end else if (m_owner < 0) begin
         m_owner = rr_pick(master_req, m_ptr, -1);
         m_cnt   = 0;
      end else if (master_req[m_owner] && slave_ack) begin
         m_ptr   = (m_owner + 1) % int'(MASTER_N);
         m_owner = rr_pick(master_req, m_ptr, m_owner);
         m_cnt   = 0;
      end else if (!master_req[m_owner]) begin
         m_ptr   = (m_owner + 1) % int'(MASTER_N);
         m_owner = -1;
      end else if (TMO_EN && m_cnt == TMO_CYC - 1) begin
         m_ptr   = (m_owner + 1) % int'(MASTER_N);
         m_owner = -1;
         m_tmo   = 1'b1;
      end else begin
         m_cnt++;
      end
   end

   // Compare process: checks every output against the model mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("mgrant", 32'(mgrant), 32'(exp_grant()));
         chk("busy", 32'(busy), 32'(m_owner >= 0));
         chk("slave_req", 32'(slave_req), 32'(m_owner >= 0 && master_req[m_owner]));
         chk("timeout", 32'(timeout), 32'(m_tmo));
         chk("onehot0", 32'($onehot0(mgrant)), 32'd1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input mgrant_t req, input logic ack);
      rst        = r;
      master_req = req;
      slave_ack  = ack;
   endtask

   initial begin
      mgrant_t order [5];
      order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
      order[3] = 4'b1000; order[4] = 4'b0001;

      tick(); tick();
      chk_en = 1'b1;
      chk("rst_mgrant", 32'(mgrant), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);

      // single requester
      drive(0, 4'b0100, 0); tick();
      chk("single_grant", 32'(mgrant), 32'h4);
      chk("single_busy", 32'(busy), 32'h1);
      tick(); tick();
      drive(0, 4'b0100, 1); tick();
      chk("single_release", 32'(mgrant), 32'h0);
      chk("single_idle", 32'(busy), 32'h0);

      // fairness, back-to-back grants
      drive(1, 4'b0000, 0); tick();
      drive(0, 4'b1111, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("fair_order", 32'(mgrant), 32'(order[i]));
      end
      drive(0, 4'b0000, 0); tick();

      // owner does not re-win on its own ack
      drive(1, 4'b0000, 0); tick();
      drive(0, 4'b0011, 0); tick();
      chk("nostarve_first", 32'(mgrant), 32'h1);
      drive(0, 4'b0011, 1); tick();
      chk("nostarve_next", 32'(mgrant), 32'h2);
      drive(0, 4'b0000, 0); tick();

      // abort, stray ack, pointer advanced to 3
      drive(1, 4'b0000, 0); tick();
      drive(0, 4'b0100, 0); tick();
      chk("abort_grant", 32'(mgrant), 32'h4);
      drive(0, 4'b0000, 0); tick();
      chk("abort_release", 32'(mgrant), 32'h0);
      drive(0, 4'b0000, 1); tick();
      chk("stray_ack", 32'(busy), 32'h0);
      drive(0, 4'b1111, 0); tick();
      chk("abort_ptr3", 32'(mgrant), 32'h8);

      // reset mid-grant
      drive(1, 4'b1111, 1); tick();
      chk("rst_mid_grant", 32'(mgrant), 32'h0);
      drive(0, 4'b1001, 0); tick();
      chk("rst_ptr0", 32'(mgrant), 32'h1);
      drive(0, 4'b0000, 0); tick();

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
      drive(1, 4'b0000, 0); tick();
      drive(0, 4'b0001, 0); tick();
      chk("tmo_grant", 32'(mgrant), 32'h1);
      for (int i = 0; i < TMO_CYC - 1; i++) begin
         tick();
         chk("tmo_hold", 32'(mgrant), 32'h1);
      end
      tick();
      chk("tmo_release", 32'(mgrant), 32'h0);
      chk("tmo_pulse", 32'(timeout), 32'h1);
      tick();
      chk("tmo_pulse_end", 32'(timeout), 32'h0);
      chk("tmo_regrant", 32'(mgrant), 32'h1);
      for (int i = 0; i < TMO_CYC - 1; i++) tick();
      drive(0, 4'b0001, 1); tick();
      chk("tmo_ack_wins", 32'(mgrant), 32'h0);
      chk("tmo_ack_nopulse", 32'(timeout), 32'h0);
      drive(0, 4'b0000, 0); tick();
`endif

      // random: frequent acks and churning requests
      for (int i = 0; i < 2000; i++) begin
         mgrant_t flip;
         flip = '0;
         for (int b = 0; b < int'(MASTER_N); b++) flip[b] = ($urandom_range(0, 3) == 0);
         drive($urandom_range(0, 99) < 2, master_req ^ flip, 1'($urandom_range(0, 1)));
         tick();
      end
      // random: sticky requests, rare acks (exercises long grants)
      for (int i = 0; i < 1500; i++) begin
         mgrant_t flip;
         flip = '0;
         for (int b = 0; b < int'(MASTER_N); b++) flip[b] = ($urandom_range(0, 39) == 0);
         drive($urandom_range(0, 199) == 0, master_req ^ flip, $urandom_range(0, 19) == 0);
         tick();
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
